// File: rtl/glay_kernel_read_responder.sv
// glay_kernel_read_responder
// Responder end of the setup/engine memory-request path. Takes single
// cacheline read requests (address + tag), issues each one as a single-beat
// AXI4 read and returns the tagged cacheline responses in request order.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   req_in_*                  request stream (valid/ready, addr, tag)
//   flush                     stop accepting requests, drain in-flight reads
//   m_axi_ar*                 AXI4 read-address channel (arlen 0, full-width)
//   m_axi_r*                  AXI4 read-data channel
//   resp_out_*                response stream (valid/ready, data, tag, error)
//   outstanding               number of AR transactions awaiting data
//   fifo_setup_signal         high while initialising after reset
//   done                      idle: nothing buffered or in flight
//
// Optional build macro GLAY_READ_RESPONDER_STATS_EN adds saturating counters
// stat_req_count, stat_resp_count and stat_error_count.

module glay_kernel_read_responder #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int INIT_CYCLES     = 4
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst_n,
  input  logic                                 req_in_valid,
  output logic                                 req_in_ready,
  input  logic [ADDR_WIDTH-1:0]                req_in_addr,
  input  logic [TAG_WIDTH-1:0]                 req_in_tag,
  input  logic                                 flush,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  output logic [ADDR_WIDTH-1:0]                m_axi_araddr,
  output logic [7:0]                           m_axi_arlen,
  output logic [2:0]                           m_axi_arsize,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready,
  input  logic [DATA_WIDTH-1:0]                m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  output logic                                 resp_out_valid,
  input  logic                                 resp_out_ready,
  output logic [DATA_WIDTH-1:0]                resp_out_data,
  output logic [TAG_WIDTH-1:0]                 resp_out_tag,
  output logic                                 resp_out_error,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 fifo_setup_signal,
  output logic                                 done
`ifdef GLAY_READ_RESPONDER_STATS_EN
  ,
  output logic [31:0]                          stat_req_count,
  output logic [31:0]                          stat_resp_count,
  output logic [15:0]                          stat_error_count
`endif
);

  localparam int OFFSET_BITS = $clog2(DATA_WIDTH / 8);
  localparam int PTR_W       = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W       = PTR_W + 1;
  localparam int INIT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_FLUSH} state_t;

  state_t                  state;
  logic [INIT_W-1:0]       init_cnt;

  logic                    req_full;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [TAG_WIDTH-1:0]    req_tag;

  logic [TAG_WIDTH-1:0]    tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        tag_wr_ptr;
  logic [PTR_W-1:0]        tag_rd_ptr;

  logic [DATA_WIDTH-1:0]   buf_data [2];
  logic [TAG_WIDTH-1:0]    buf_tag  [2];
  logic                    buf_err  [2];
  logic                    buf_head;
  logic [1:0]              buf_count;
  logic                    buf_tail;

  logic req_accept, ar_hs, r_hs, r_accept, resp_pop, drained;
  logic unused_inputs;

  // Request byte offset and the rresp LSB carry no information for this block.
  assign unused_inputs = ^{req_in_addr[OFFSET_BITS-1:0], m_axi_rresp[0]};

  assign ar_hs      = m_axi_arvalid & m_axi_arready;
  assign r_hs       = m_axi_rvalid & m_axi_rready;
  // A beat with no matching tag is a protocol violation and is dropped.
  assign r_accept   = r_hs & (outstanding != '0);
  assign resp_pop   = resp_out_valid & resp_out_ready;

  // flush gates ready directly so acceptance stops in the same cycle.
  assign req_in_ready = ((state == S_IDLE) || (state == S_ACTIVE)) & ~flush &
                        (~req_full | ar_hs);
  assign req_accept   = req_in_valid & req_in_ready;

  assign m_axi_arvalid = req_full & (outstanding < MAX_CNT);
  assign m_axi_araddr  = req_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(OFFSET_BITS);

  // rready is held low during INIT so every handshake output resets to 0.
  assign m_axi_rready   = (state != S_INIT) & (buf_count != 2'd2);
  assign resp_out_valid = (buf_count != 2'd0);
  assign resp_out_data  = buf_data[buf_head];
  assign resp_out_tag   = buf_tag[buf_head];
  assign resp_out_error = buf_err[buf_head];
  assign buf_tail       = buf_head ^ buf_count[0];

  // The pending request register counts as work, otherwise ACTIVE could fall
  // back to IDLE in the cycle between acceptance and the AR handshake.
  assign drained = (outstanding == '0) && (buf_count == 2'd0) && !req_full && !req_accept;

  // Control FSM; fifo_setup_signal and done are registered alongside state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state             <= S_INIT;
      init_cnt          <= '0;
      fifo_setup_signal <= 1'b1;
      done              <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state             <= S_IDLE;
            fifo_setup_signal <= 1'b0;
            done              <= 1'b1;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        S_IDLE: begin
          if (req_accept) begin
            state <= S_ACTIVE;
            done  <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (flush) begin
            state <= S_FLUSH;
          end else if (drained) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (!flush && drained) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // One-entry request register; the address is stored line-aligned.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      req_full <= 1'b0;
      req_addr <= '0;
      req_tag  <= '0;
    end else if (req_accept) begin
      req_full <= 1'b1;
      req_addr <= {req_in_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
      req_tag  <= req_in_tag;
    end else if (ar_hs) begin
      req_full <= 1'b0;
    end
  end

  // Tag storage needs no reset; the pointers alone define its contents.
  always_ff @(posedge ap_clk) begin
    if (ar_hs) begin
      tag_mem[tag_wr_ptr] <= req_tag;
    end
  end

  // Tag FIFO pointers and in-flight count. Occupancy equals outstanding.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      outstanding <= '0;
    end else begin
      if (ar_hs)    tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
      if (r_accept) tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
      case ({ar_hs, r_accept})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Two-entry response skid buffer; the head entry drives resp_out_*.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_tag[i]  <= '0;
        buf_err[i]  <= 1'b0;
      end
      buf_head  <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (r_accept) begin
        buf_data[buf_tail] <= m_axi_rdata;
        buf_tag[buf_tail]  <= tag_mem[tag_rd_ptr];
        buf_err[buf_tail]  <= m_axi_rresp[1];
      end
      if (resp_pop) buf_head <= ~buf_head;
      case ({r_accept, resp_pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

`ifdef GLAY_READ_RESPONDER_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_req_count   <= '0;
      stat_resp_count  <= '0;
      stat_error_count <= '0;
    end else begin
      if (ar_hs && (stat_req_count != '1))
        stat_req_count <= stat_req_count + 32'd1;
      if (resp_pop && (stat_resp_count != '1))
        stat_resp_count <= stat_resp_count + 32'd1;
      if (r_hs && m_axi_rresp[1] && (stat_error_count != '1))
        stat_error_count <= stat_error_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_glay_kernel_read_responder.sv
// tb_glay_kernel_read_responder
// Randomised bench for glay_kernel_read_responder. A queue-level model tracks
// accepted requests, in-flight reads and buffered responses; an AXI slave
// model returns random cachelines in order.

module tb_glay_kernel_read_responder;

  localparam int AW   = 64;
  localparam int DW   = 512;
  localparam int TW   = 8;
  localparam int MAXO = 16;

  logic           ap_clk = 1'b0;
  logic           ap_rst_n = 1'b0;
  logic           req_in_valid = 1'b0;
  logic           req_in_ready;
  logic [AW-1:0]  req_in_addr = '0;
  logic [TW-1:0]  req_in_tag = '0;
  logic           flush = 1'b0;
  logic           m_axi_arvalid;
  logic           m_axi_arready = 1'b0;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic           m_axi_rvalid = 1'b0;
  logic           m_axi_rready;
  logic [DW-1:0]  m_axi_rdata = '0;
  logic [1:0]     m_axi_rresp = 2'b00;
  logic           resp_out_valid;
  logic           resp_out_ready = 1'b0;
  logic [DW-1:0]  resp_out_data;
  logic [TW-1:0]  resp_out_tag;
  logic           resp_out_error;
  logic [4:0]     outstanding;
  logic           fifo_setup_signal;
  logic           done;
`ifdef GLAY_READ_RESPONDER_STATS_EN
  logic [31:0]    stat_req_count;
  logic [31:0]    stat_resp_count;
  logic [15:0]    stat_error_count;
`endif

  glay_kernel_read_responder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
    .req_in_addr(req_in_addr), .req_in_tag(req_in_tag), .flush(flush),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .resp_out_valid(resp_out_valid), .resp_out_ready(resp_out_ready),
    .resp_out_data(resp_out_data), .resp_out_tag(resp_out_tag),
    .resp_out_error(resp_out_error), .outstanding(outstanding),
    .fifo_setup_signal(fifo_setup_signal), .done(done)
`ifdef GLAY_READ_RESPONDER_STATS_EN
    , .stat_req_count(stat_req_count), .stat_resp_count(stat_resp_count),
    .stat_error_count(stat_error_count)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {logic [AW-1:0] addr; logic [TW-1:0] tag;} req_t;
  typedef struct {logic [DW-1:0] data; logic [TW-1:0] tag; logic err;} resp_t;

  req_t          todo_q[$];
  req_t          accepted_q[$];
  logic [TW-1:0] inflight_q[$];
  resp_t         exp_q[$];

  int checks = 0;
  int failures = 0;
  int r_enable = 1, r_mode = 0, ar_mode = 0, ready_mode = 0;
  int cycle = 0, slave_pending = 0, beat_total = 0, err_beat = -1;
  int ar_total = 0, resp_total = 0, err_resp_total = 0, full_seen = 0;
  bit req_fire = 0, ar_fire = 0, r_fire = 0, resp_fire = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] randLine();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives all bench-side inputs just after the active edge.
  task automatic applyStimulus();
    req_t r;
    if (!req_in_valid || req_fire) begin
      if (todo_q.size() > 0) begin
        r = todo_q.pop_front();
        req_in_valid = 1'b1;
        req_in_addr  = r.addr;
        req_in_tag   = r.tag;
      end else begin
        req_in_valid = 1'b0;
      end
    end
    m_axi_arready = (ar_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (!m_axi_rvalid || r_fire) begin
      if (r_enable != 0 && slave_pending > 0 && (r_mode == 0 || $urandom_range(0, 3) != 0)) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = randLine();
        m_axi_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
      end
    end
    case (ready_mode)
      0:       resp_out_ready = 1'b1;
      1:       resp_out_ready = 1'($urandom_range(0, 1));
      default: resp_out_ready = ((cycle / 3) % 2) == 0;
    endcase
    cycle++;
  endtask

  // Compares the DUT against the model at the falling edge, then records the
  // handshakes that the next rising edge will complete.
  task automatic stepCycle();
    logic [TW-1:0] t;
    @(negedge ap_clk);
    checkOutput("outstanding", outstanding, inflight_q.size());
    checkOutput("arvalid", m_axi_arvalid, (accepted_q.size() > 0) && (inflight_q.size() < MAXO));
    checkOutput("rready", m_axi_rready, exp_q.size() < 2);
    checkOutput("resp_valid", resp_out_valid, exp_q.size() > 0);
    if (exp_q.size() == 2) full_seen++;
    if (m_axi_arvalid && accepted_q.size() > 0) begin
      checkOutput("araddr", m_axi_araddr, {accepted_q[0].addr[AW-1:6], 6'b0});
      checkOutput("arlen", m_axi_arlen, 8'd0);
      checkOutput("arsize", m_axi_arsize, 3'd6);
    end
    if (resp_out_valid && exp_q.size() > 0) begin
      checkOutput("resp_tag", resp_out_tag, exp_q[0].tag);
      checkOutput("resp_data", resp_out_data, exp_q[0].data);
      checkOutput("resp_error", resp_out_error, exp_q[0].err);
    end
    req_fire  = req_in_valid && req_in_ready;
    ar_fire   = m_axi_arvalid && m_axi_arready;
    r_fire    = m_axi_rvalid && m_axi_rready;
    resp_fire = resp_out_valid && resp_out_ready;
    if (resp_fire) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      resp_total++;
      if (resp_out_error) err_resp_total++;
    end
    if (r_fire) begin
      if (inflight_q.size() > 0) begin
        t = inflight_q.pop_front();
        exp_q.push_back('{data: m_axi_rdata, tag: t, err: m_axi_rresp[1]});
      end
      slave_pending--;
      beat_total++;
    end
    if (ar_fire && accepted_q.size() > 0) begin
      inflight_q.push_back(accepted_q[0].tag);
      void'(accepted_q.pop_front());
      slave_pending++;
      ar_total++;
    end
    if (req_fire) accepted_q.push_back('{addr: req_in_addr, tag: req_in_tag});
    @(posedge ap_clk);
    #1;
    applyStimulus();
  endtask

  task automatic runUntilDrained(input int bound);
    int n = 0;
    while ((todo_q.size() + accepted_q.size() + inflight_q.size() + exp_q.size() > 0 ||
            req_in_valid) && n < bound) begin
      stepCycle();
      n++;
    end
    if (n >= bound)
      checkOutput("drain_timeout", todo_q.size() + accepted_q.size() + inflight_q.size() + exp_q.size(), 0);
  endtask

  task automatic queueRandom(input int count, input int tag_base);
    for (int i = 0; i < count; i++)
      todo_q.push_back('{addr: {$urandom, $urandom}, tag: TW'(tag_base + i)});
  endtask

  task automatic waitInit();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    checkOutput("init_setup0", fifo_setup_signal, 1'b1);
    checkOutput("init_done0", done, 1'b0);
    checkOutput("init_arvalid", m_axi_arvalid, 1'b0);
    checkOutput("init_req_ready", req_in_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge ap_clk);
      #1;
      checkOutput("init_setup", fifo_setup_signal, i < 4);
    end
    checkOutput("init_done", done, 1'b1);
    checkOutput("init_rready", m_axi_rready, 1'b1);
  endtask

  initial begin
    int base;
    // Reset values while held in reset.
    repeat (3) @(posedge ap_clk);
    #1;
    checkOutput("rst_resp_valid", resp_out_valid, 1'b0);
    checkOutput("rst_rready", m_axi_rready, 1'b0);
    checkOutput("rst_data", resp_out_data, '0);
    waitInit();

    // Single request, unaligned address.
    todo_q.push_back('{addr: 64'h0000_0000_1000_0047, tag: 8'h5A});
    runUntilDrained(200);
    repeat (2) stepCycle();
    checkOutput("single_done", done, 1'b1);

    // Back-to-back requests beyond the outstanding limit, R channel stalled.
    r_enable = 0;
    base = ar_total;
    queueRandom(20, 8'h10);
    repeat (60) stepCycle();
    checkOutput("ar_issued_16", ar_total - base, 16);
    checkOutput("outstanding_16", outstanding, 16);
    checkOutput("req_ready_full", req_in_ready, 1'b0);
    r_enable = 1;
    runUntilDrained(600);
    repeat (2) stepCycle();
    checkOutput("b2b_done", done, 1'b1);

    // Consumer toggling every 3 cycles.
    ready_mode = 2;
    full_seen = 0;
    queueRandom(10, 8'h40);
    runUntilDrained(600);
    checkOutput("buf_full_seen", full_seen > 0, 1'b1);
    ready_mode = 0;

    // Error response on the third of five requests.
    err_beat = beat_total + 2;
    base = err_resp_total;
    queueRandom(5, 8'h60);
    runUntilDrained(300);
    checkOutput("error_resp_count", err_resp_total - base, 1);
`ifdef GLAY_READ_RESPONDER_STATS_EN
    checkOutput("stat_error", stat_error_count, 1);
    checkOutput("stat_resp", stat_resp_count, resp_total);
    checkOutput("stat_req", stat_req_count, ar_total);
`endif
    err_beat = -1;

    // Flush with six reads in flight.
    r_enable = 0;
    queueRandom(6, 8'h80);
    for (int i = 0; i < 100 && inflight_q.size() < 6; i++) stepCycle();
    checkOutput("flush_inflight", outstanding, 6);
    flush = 1'b1;
    #1;
    checkOutput("flush_ready", req_in_ready, 1'b0);
    r_enable = 1;
    runUntilDrained(300);
    repeat (2) stepCycle();
    checkOutput("flush_hold", done, 1'b0);
    checkOutput("flush_ready_hold", req_in_ready, 1'b0);
    flush = 1'b0;
    repeat (2) stepCycle();
    checkOutput("flush_done", done, 1'b1);

    // Fully random handshakes.
    ar_mode = 1; r_mode = 1; ready_mode = 1;
    queueRandom(30, 8'hA0);
    runUntilDrained(2000);
    ar_mode = 0; r_mode = 0; ready_mode = 0;

    // Asynchronous reset in the middle of a stream.
    queueRandom(10, 8'hD0);
    repeat (8) stepCycle();
    #2;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_arvalid", m_axi_arvalid, 1'b0);
    checkOutput("mid_rst_rready", m_axi_rready, 1'b0);
    checkOutput("mid_rst_req_ready", req_in_ready, 1'b0);
    checkOutput("mid_rst_resp_valid", resp_out_valid, 1'b0);
    checkOutput("mid_rst_outstanding", outstanding, 0);
    checkOutput("mid_rst_setup", fifo_setup_signal, 1'b1);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_tag", resp_out_tag, 0);
    checkOutput("mid_rst_araddr", m_axi_araddr, 0);
    todo_q.delete(); accepted_q.delete(); inflight_q.delete(); exp_q.delete();
    slave_pending = 0;
    req_in_valid = 1'b0; m_axi_rvalid = 1'b0;
    req_fire = 0; ar_fire = 0; r_fire = 0; resp_fire = 0;
    repeat (2) @(posedge ap_clk);
    waitInit();
    queueRandom(3, 8'hF0);
    runUntilDrained(200);
    repeat (4) stepCycle();
    checkOutput("post_rst_done", done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
